ram_cmd_arbiter: RTL and testbench
==================================

// Module: ram_cmd_arbiter
// PURPOSE
//  Shares the single-port RAM command interface (10-bit din = {opcode[1:0], byte[7:0]}, rx_valid in;
//  dout[7:0], tx_valid out) between NREQ requesters. Each granted transaction is issued as an atomic
//  two-command sequence, so requests from the SPI slave and other masters never interleave.
//  Arbitration is round-robin. Sits between the requester logic and the RAM.
// PARAMETERS
//  NREQ        2   number of requesters (>=2)
//  RD_TIMEOUT  4   max cycles spent in WAIT_RD waiting for ram_tx_valid before aborting (>=1)
// PORTS
//  clk          in   1        single clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  req          in   NREQ     per-requester transaction request (level, held until ack)
//  req_we       in   NREQ     1 = write, 0 = read
//  req_addr     in   NREQ*8   packed byte addresses, requester i at [8i+7:8i]
//  req_wdata    in   NREQ*8   packed write data, same packing
//  ack          out  NREQ     one-cycle completion pulse to the served requester
//  rdata        out  8        read data, valid while ack is high (read only)
//  err          out  1        read timeout flag, valid while ack is high
//  ram_din      out  10       RAM command word {opcode, byte}
//  ram_rx_valid out  1        RAM command strobe
//  ram_dout     in   8        RAM read data
//  ram_tx_valid in   1        RAM read data valid
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, ack=0, rdata=0, err=0, ram_din=0, ram_rx_valid=0,
//   round-robin pointer last=NREQ-1 (requester 0 wins first), timeout counter=0.
//  All outputs are registered. Opcodes: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
//  FSM:
//   IDLE    if any req: winner = first set bit searching last+1, last+2, ... (mod NREQ); latch
//           we/addr/wdata of winner; -> ADDR. No req: stay, ram_rx_valid=0.
//   ADDR    ram_din={we?00:10, addr}, ram_rx_valid=1; -> DATA.
//   DATA    ram_din={we?01:11, we?wdata:8'h00}, ram_rx_valid=1; write -> DONE, read -> WAIT_RD.
//   WAIT_RD ram_rx_valid=0; counter increments each cycle. ram_tx_valid=1: rdata<=ram_dout,
//           err<=0, -> DONE. Counter reaches RD_TIMEOUT with no tx_valid: rdata<=0, err<=1, -> DONE.
//   DONE    ack[winner]=1 for exactly one cycle; last<=winner; counter cleared; -> IDLE.
//  ram_rx_valid is 0 in IDLE, WAIT_RD and DONE.
//  Latency (req high in IDLE cycle 0, no cache hit): write ack in cycle 3, read ack in cycle 4.
//  Handshake: requester holds req, we, addr, wdata stable until ack; it drops req on the edge
//   where it samples ack high. A req seen in the IDLE cycle after DONE is a new transaction.
//   Inputs of non-winning requesters are ignored until the next IDLE.
//  Stale tx_valid: only tx_valid sampled in WAIT_RD counts. The RAM clears it on the ADDR command.
//  req deasserted mid-transaction: the transaction still completes and ack still pulses.
//  Simultaneous reqs: exactly one winner per IDLE. The others wait at most NREQ-1 transactions.
//  Reset mid-operation: the sequence is abandoned, no ack, and the RAM may hold a half-updated
//   address register. Both blocks share rst_n, so the RAM address registers also clear.
// CONFIGURATION
//  ADDR_CACHE_EN defined: keep shadow wr_addr/rd_addr registers plus valid bits (valid=0 on reset),
//   updated whenever an ADDR state issues. If the latched addr equals the shadow and its valid bit
//   is 1, IDLE goes straight to DATA and skips ADDR, so latency is 1 cycle shorter.
//   The write and read shadows are independent.
//  ADDR_CACHE_EN undefined: every transaction issues ADDR; no shadow registers are present.
// TESTING
//  1 req[0] write addr=8'h3C data=8'hA5 -> ram_din 10'h03C then 10'h1A5 on consecutive cycles,
//    ack[0] in cycle 3, err=0.
//  2 req[1] read addr=8'h3C after test 1 -> ram_din 10'h23C, 10'h300; rdata=8'hA5 with ack[1]
//    in cycle 4.
//  3 req=2'b11 held continuously after reset -> grants alternate 0,1,0,1; no requester served twice
//    in a row.
//  4 read with RAM model withholding tx_valid -> ack after RD_TIMEOUT WAIT_RD cycles, err=1,
//    rdata=8'h00.
//  5 rst_n low during DATA of a write -> all outputs 0 immediately, no ack; next req served from
//    IDLE normally.
//  6 ADDR_CACHE_EN: two writes to 8'h10 back-to-back -> second issues only 10'h1xx, ack in cycle 2;
//    macro undefined -> both issue 10'h010, ack in cycle 3.

Source files
------------

// File: rtl/ram_cmd_arbiter_if.sv
// ram_cmd_arbiter_if: requester-side bundle of the RAM command arbiter.
// NREQ requesters, addr/wdata packed 8 bits per requester.
interface ram_cmd_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_we;
  logic [NREQ*8-1:0] req_addr;
  logic [NREQ*8-1:0] req_wdata;
  logic [NREQ-1:0]   ack;
  logic [7:0]        rdata;
  logic              err;

  modport master (
    output req, req_we, req_addr, req_wdata,
    input  ack, rdata, err
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata,
    output ack, rdata, err
  );
endinterface

// File: rtl/ram_cmd_arbiter.sv
// ram_cmd_arbiter: round-robin sharing of the RAM command port.
// Define ADDR_CACHE_EN to skip ADDR when the RAM already holds the address.
module ram_cmd_arbiter #(
  parameter int NREQ       = 2,
  parameter int RD_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_cmd_arbiter_if.slave bus,
  output logic [9:0]       ram_din,
  output logic             ram_rx_valid,
  input  logic [7:0]       ram_dout,
  input  logic             ram_tx_valid
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(RD_TIMEOUT + 1);

  typedef logic [IW-1:0] idx_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WAIT_RD,
    DONE
  } state_t;

  state_t          state;
  idx_t            last;
  idx_t            win;
  idx_t            nxt;
  logic            we_q;
  logic [7:0]      wdata_q;
  logic [CW-1:0]   cnt;
  logic            sel_we;
  logic [7:0]      sel_addr;
  logic [7:0]      sel_wdata;
  logic [NREQ-1:0] win_oh;
  logic            hit;

  function automatic logic [9:0] data_cmd(
    input logic       we,
    input logic [7:0] d
  );
    return we ? {2'b01, d} : {2'b11, 8'h00};
  endfunction

  // Lowest k (closest after last) is assigned last, so it wins.
  always_comb begin
    nxt = last;
    for (int k = NREQ; k >= 1; k--) begin
      if (bus.req[idx_t'((int'(last) + k) % NREQ)])
        nxt = idx_t'((int'(last) + k) % NREQ);
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = 8'h00;
    sel_wdata = 8'h00;
    win_oh    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (idx_t'(i) == nxt) begin
        sel_we    = bus.req_we[i];
        sel_addr  = bus.req_addr[8*i +: 8];
        sel_wdata = bus.req_wdata[8*i +: 8];
      end
      win_oh[i] = (idx_t'(i) == win);
    end
  end

`ifdef ADDR_CACHE_EN
  logic [7:0] wr_sh;
  logic [7:0] rd_sh;
  logic       wr_v;
  logic       rd_v;

  always_comb begin
    if (sel_we)
      hit = wr_v && (wr_sh == sel_addr);
    else
      hit = rd_v && (rd_sh == sel_addr);
  end

  // Shadows track the RAM's own address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sh <= 8'h00;
      rd_sh <= 8'h00;
      wr_v  <= 1'b0;
      rd_v  <= 1'b0;
    end else if (state == IDLE && |bus.req && !hit) begin
      if (sel_we) begin
        wr_sh <= sel_addr;
        wr_v  <= 1'b1;
      end else begin
        rd_sh <= sel_addr;
        rd_v  <= 1'b1;
      end
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last         <= idx_t'(NREQ - 1);
      win          <= '0;
      we_q         <= 1'b0;
      wdata_q      <= 8'h00;
      cnt          <= '0;
      bus.ack      <= '0;
      bus.rdata    <= 8'h00;
      bus.err      <= 1'b0;
      ram_din      <= 10'h000;
      ram_rx_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.ack      <= '0;
          ram_rx_valid <= 1'b0;
          if (|bus.req) begin
            win          <= nxt;
            we_q         <= sel_we;
            wdata_q      <= sel_wdata;
            ram_rx_valid <= 1'b1;
            if (hit) begin
              state   <= DATA;
              ram_din <= data_cmd(sel_we, sel_wdata);
            end else begin
              state   <= ADDR;
              ram_din <= {sel_we ? 2'b00 : 2'b10, sel_addr};
            end
          end
        end
        ADDR: begin
          state        <= DATA;
          ram_din      <= data_cmd(we_q, wdata_q);
          ram_rx_valid <= 1'b1;
        end
        DATA: begin
          ram_rx_valid <= 1'b0;
          cnt          <= '0;
          if (we_q) begin
            state   <= DONE;
            bus.ack <= win_oh;
            bus.err <= 1'b0;
          end else begin
            state <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (ram_tx_valid) begin
            bus.rdata <= ram_dout;
            bus.err   <= 1'b0;
            bus.ack   <= win_oh;
            state     <= DONE;
          end else if (cnt == CW'(RD_TIMEOUT - 1)) begin
            bus.rdata <= 8'h00;
            bus.err   <= 1'b1;
            bus.ack   <= win_oh;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          bus.ack <= '0;
          last    <= win;
          cnt     <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// tb_ram_cmd_arbiter: directed and random checks of ram_cmd_arbiter
// against a transaction-level model and a simple RAM model.
module tb_ram_cmd_arbiter;
  localparam int RD_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;

  ram_cmd_arbiter_if #(.NREQ(2)) bus ();

  ram_cmd_arbiter #(
    .NREQ(2),
    .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .ram_din(ram_din),
    .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout),
    .ram_tx_valid(ram_tx_valid)
  );

  always #5 clk = ~clk;

  // RAM with separate write/read address registers.
  logic [7:0] mem [256];
  logic [7:0] wa;
  logic [7:0] ra;
  logic       withhold = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa           <= 8'h00;
      ra           <= 8'h00;
      ram_tx_valid <= 1'b0;
      ram_dout     <= 8'h00;
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else begin
      ram_tx_valid <= 1'b0;
      if (ram_rx_valid) begin
        case (ram_din[9:8])
          2'b00: wa <= ram_din[7:0];
          2'b01: mem[wa] <= ram_din[7:0];
          2'b10: ra <= ram_din[7:0];
          default: begin
            if (!withhold) begin
              ram_tx_valid <= 1'b1;
              ram_dout     <= mem[ra];
            end
          end
        endcase
      end
    end
  end

  logic [9:0] cmds [$];

  always @(negedge clk) begin
    if (rst_n && ram_rx_valid) cmds.push_back(ram_din);
  end

  int         total = 0;
  int         bad = 0;
  logic [7:0] ref_mem [256];
  int         rr_last;
  logic       wv;
  logic       rv;
  logic [7:0] wsh;
  logic [7:0] rsh;
  logic [1:0] last_ack;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    rr_last = 1;
    wv      = 1'b0;
    rv      = 1'b0;
    wsh     = 8'h00;
    rsh     = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
  endtask

  function automatic logic model_hit(input logic iswe, input logic [7:0] a);
`ifdef ADDR_CACHE_EN
    return iswe ? (wv && wsh == a) : (rv && rsh == a);
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_txn(input logic [1:0] mask, input logic [1:0] we,
                         input logic [15:0] addr, input logic [15:0] data,
                         input string tag);
    int         w;
    int         k;
    int         lat;
    logic       iswe;
    logic       hit;
    logic [7:0] a;
    logic [7:0] d;
    logic [9:0] want [$];

    if (rr_last == 0) w = mask[1] ? 1 : 0;
    else w = mask[0] ? 0 : 1;
    iswe = w == 1 ? we[1] : we[0];
    a    = w == 1 ? addr[15:8] : addr[7:0];
    d    = w == 1 ? data[15:8] : data[7:0];
    hit  = model_hit(iswe, a);

    want = {};
    if (!hit) want.push_back({iswe ? 2'b00 : 2'b10, a});
    want.push_back(iswe ? {2'b01, d} : {2'b11, 8'h00});
    if (iswe) lat = 3;
    else if (withhold) lat = 3 + RD_TIMEOUT;
    else lat = 4;
    if (hit) lat = lat - 1;

    cmds.delete();
    bus.req       = mask;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.ack == 2'b00 && k < 30);
    last_ack = bus.ack;

    check({tag, "_ack"}, 32'(bus.ack), (w == 0) ? 32'd1 : 32'd2);
    check({tag, "_lat"}, 32'(k), 32'(lat));
    check({tag, "_ncmd"}, 32'(cmds.size()), 32'(want.size()));
    for (int i = 0; i < want.size(); i++) begin
      if (i < cmds.size())
        check({tag, "_cmd"}, 32'(cmds[i]), 32'(want[i]));
    end
    if (iswe) begin
      ref_mem[a] = d;
      check({tag, "_err"}, 32'(bus.err), 32'd0);
    end else begin
      check({tag, "_rdata"}, 32'(bus.rdata),
            withhold ? 32'd0 : 32'(ref_mem[a]));
      check({tag, "_err"}, 32'(bus.err), withhold ? 32'd1 : 32'd0);
    end

    bus.req = 2'b00;
    rr_last = w;
    if (!hit) begin
      if (iswe) begin
        wsh = a;
        wv  = 1'b1;
      end else begin
        rsh = a;
        rv  = 1'b1;
      end
    end
    @(negedge clk);
    check({tag, "_ackpulse"}, 32'(bus.ack), 32'd0);
  endtask

  initial begin
    bus.req       = 2'b00;
    bus.req_we    = 2'b00;
    bus.req_addr  = 16'h0000;
    bus.req_wdata = 16'h0000;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_din", 32'(ram_din), 32'd0);
    check("rst_rxv", 32'(ram_rx_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(2'b01, 2'b01, 16'h003C, 16'h00A5, "wr3c");
    run_txn(2'b10, 2'b00, 16'h3C00, 16'h0000, "rd3c");

    withhold = 1'b1;
    run_txn(2'b01, 2'b00, 16'h003C, 16'h0000, "tmo");
    withhold = 1'b0;

    run_txn(2'b01, 2'b01, 16'h0010, 16'h0011, "wr10a");
    run_txn(2'b01, 2'b01, 16'h0010, 16'h0022, "wr10b");

    // Reset while the DATA command of a write is on the bus.
    begin
      int n;
      n = model_hit(1'b1, 8'h55) ? 1 : 2;
      bus.req       = 2'b01;
      bus.req_we    = 2'b01;
      bus.req_addr  = 16'h0055;
      bus.req_wdata = 16'h0077;
      repeat (n) @(negedge clk);
      check("mid_rxv", 32'(ram_rx_valid), 32'd1);
      check("mid_op", 32'(ram_din[9:8]), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_ack", 32'(bus.ack), 32'd0);
      check("mid_rdata", 32'(bus.rdata), 32'd0);
      check("mid_err", 32'(bus.err), 32'd0);
      check("mid_din", 32'(ram_din), 32'd0);
      check("mid_rxv0", 32'(ram_rx_valid), 32'd0);
      bus.req = 2'b00;
      repeat (3) begin
        @(negedge clk);
        check("mid_noack", 32'(bus.ack), 32'd0);
      end
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
    end
    run_txn(2'b01, 2'b00, 16'h0055, 16'h0000, "post_rst_rd");
    run_txn(2'b10, 2'b10, 16'h5500, 16'h9900, "post_rst_wr");

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      run_txn(2'b11, 2'b11, 16'h2120, {8'(i + 8'h80), 8'(i)}, "rr");
      check("rr_order", 32'(last_ack), (i % 2 == 0) ? 32'd1 : 32'd2);
    end

    for (int n = 0; n < 40; n++) begin
      logic [1:0]  m;
      logic [15:0] ad;
      m  = 2'($urandom_range(1, 3));
      ad = {8'($urandom_range(0, 3)) + 8'h40, 8'($urandom_range(0, 3)) + 8'h40};
      run_txn(m, 2'($urandom), ad, 16'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
